// File: rtl/kyber_rej_sampler.sv
// Uniform rejection sampler: cuts the SHAKE squeeze stream into 12-bit candidates, writes those < Q to ntt_core.
// Latency: a write appears one cycle after its candidate is evaluated; 1 candidate/cycle plus 1 load cycle per word.
// Backpressure: squeeze_ready is high only while fewer than CW bits are buffered; no ready input on the write side.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse, begins one polynomial (ignored while busy)
//   squeeze_valid/ready/data   64-bit LSB-first sponge stream (transfer = valid && ready)
//   mem_wr_en/addr/data registered coefficient write port toward ntt_core
//   busy, done          run in progress / one-cycle pulse with the write of coefficient N-1
//   reject_cnt          rejected candidates in the current/last run, saturating
module kyber_rej_sampler #(
   parameter int Q  = 3329,
   parameter int N  = 256,
   parameter int DW = 64,
   parameter int CW = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 squeeze_valid,
   input  logic [DW-1:0]        squeeze_data,
   output logic                 squeeze_ready,
   output logic                 mem_wr_en,
   output logic [$clog2(N)-1:0] mem_wr_addr,
   output logic [15:0]          mem_wr_data,
   output logic                 busy,
   output logic                 done,
   output logic [15:0]          reject_cnt
);

   localparam int BW = DW + CW;        // worst case: CW-1 leftover bits plus one full word
   localparam int AW = $clog2(N);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [BW-1:0]   r_buf;
   logic [6:0]      r_cnt;
   logic [AW-1:0]   r_idx;
   logic [15:0]     r_rej;
   logic            r_wr_en;
   logic [AW-1:0]   r_wr_addr;
   logic [15:0]     r_wr_data;
   logic            r_done;

   logic            w_run;
   logic            w_need;
   logic            w_load;
   logic            w_eval;
   logic [CW-1:0]   w_cand;
   logic            w_accept;
   logic            w_last;

   // Load and evaluate are mutually exclusive by construction (cnt < CW vs cnt >= CW).
   assign w_run    = (r_state == S_RUN);
   assign w_need   = (r_cnt < 7'(CW));
   assign w_load   = w_run && w_need && squeeze_valid;
   assign w_eval   = w_run && !w_need;
   assign w_cand   = r_buf[CW-1:0];
   assign w_accept = w_eval && (w_cand < CW'(Q));
   assign w_last   = w_accept && (r_idx == AW'(N - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_buf     <= '0;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_rej     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;

         if ((r_state == S_IDLE) && start) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_idx <= '0;
            r_rej <= '0;
         end

         // Bits above r_cnt are always zero (cleared on start, zero-filled by the shift),
         // so OR-ing the new word in at offset r_cnt joins straddling fields exactly.
         if (w_load) begin
            r_buf <= r_buf | (BW'(squeeze_data) << r_cnt);
            r_cnt <= r_cnt + 7'(DW);
         end

         if (w_eval) begin
            r_buf <= r_buf >> CW;
            r_cnt <= r_cnt - 7'(CW);
            if (w_accept) begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_idx;
               r_wr_data <= 16'(w_cand);
               r_done    <= w_last;
               if (!w_last) r_idx <= r_idx + 1'b1;
            end else if (r_rej != 16'hFFFF) begin
               r_rej <= r_rej + 16'd1;
            end
         end
      end
   end

   assign squeeze_ready = w_run && w_need;
   assign busy          = w_run;
   assign mem_wr_en     = r_wr_en;
   assign mem_wr_addr   = r_wr_addr;
   assign mem_wr_data   = r_wr_data;
   assign done          = r_done;
   assign reject_cnt    = r_rej;

endmodule
